layer_priority_mixer: RTL and testbench
=======================================

# layer_priority_mixer

Parametrised, pipelined successor to the combinational two-sprite mixer. It merges `N_LAYERS` colour/visibility layers (menu overlay, sprites, effects) over a background colour using fixed index priority. Each layer has a colour-key transparency test, a per-frame enable mask shadowed at frame start, and a frame-counted flash (blink) mode. It also reports a per-frame sticky collision mask. It sits between the layer generators and the VGA output register.

## Interface
- `N_LAYERS`, default 4: number of layers; layer 0 has the highest priority. Legal range is 2..8.
- `COLOR_W`, default 8: pixel colour width (RRRGGGBB when 8).
- `KEY_EN`, default 1: when 1, a layer pixel whose colour equals `KEY_COLOR` is treated as transparent.
- `KEY_COLOR`, default 8'hE3: transparency key value.
- `FLASH_DIV`, default 8: number of frames per flash half-period. Legal range is 1..255.

Ports:
- `clk`  input  1  pixel clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `de_in`  input  1  display enable for the current pixel.
- `frame_start`  input  1  one-cycle pulse, coincident with the first pixel (x=0, y=0) of a frame.
- `bg_color`  input  COLOR_W  background colour for the current pixel.
- `layer_color`  input  N_LAYERS*COLOR_W  packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- `layer_visible`  input  N_LAYERS  raw per-layer visibility flags.
- `layer_enable_in`  input  N_LAYERS  requested enable mask; sampled only on `frame_start`.
- `layer_flash`  input  N_LAYERS  layers subject to flash blanking; used live, not shadowed.
- `de_out`  output  1  `de_in` delayed by 2 cycles.
- `pixel_out`  output  COLOR_W  mixed colour, aligned with `de_out`.
- `collision_mask`  output  N_LAYERS  bit i set when layer i overlapped another layer in the completed frame.
- `collision_valid`  output  1  one-cycle pulse when `collision_mask` updates.
- `flash_phase`  output  1  current blink phase; 1 means flashing layers are hidden.

## Operation
- Shadow enable register `en_sh`, reset value all-ones. On `frame_start`, `en_sh <= layer_enable_in`.
- Effective enable `en_eff = frame_start ? layer_enable_in : en_sh`. The first pixel of a frame therefore already uses the new mask.
- Effective visibility for layer i is `vis_i = layer_visible[i] & en_eff[i] & ~(KEY_EN & color_i==KEY_COLOR) & ~(layer_flash[i] & flash_phase)`.
- Flash counter `fcnt`, width 8, reset 0:
  - It increments on each `frame_start`.
  - When it reaches `FLASH_DIV-1` it wraps to 0 and toggles `flash_phase`.
  - `flash_phase` resets to 0. A toggle takes effect on the cycle after the `frame_start` that caused it.
- Mix priority:
  - If `de` is 0, the output is all zeros.
  - Otherwise the output is the colour of the lowest-index layer with `vis_i` set.
  - If no layer is visible, the output is `bg_color`.
- Collision:
  - Per-pixel hit: `hit_i = de_in & vis_i & (popcount(vis) >= 2)`.
  - Sticky accumulator `acc`, reset 0: `acc <= acc | hit` on every cycle.
  - On a `frame_start` cycle: `collision_mask <= acc` (the previous frame, excluding the current pixel), then `acc <= hit` (current pixel only).
- `collision_valid` is high for the one cycle after `frame_start`. `collision_mask` holds until the next `frame_start`.
- The first `frame_start` after reset reports whatever partial frame was accumulated. Software ignores the first `collision_valid` after reset.

## Timing
- Stage 0 to stage 1 (registered):
  - Qualifies visibility.
  - Registers the colours, `vis`, `de` and `bg_color`.
- Stage 1 to stage 2 (registered):
  - Resolves priority.
  - Registers `pixel_out` and `de_out`.
- Fixed latency is 2 cycles for every input. There is no backpressure and no stall.
- Reset values: `de_out`=0, `pixel_out`=0, `collision_mask`=0, `collision_valid`=0, `flash_phase`=0. Internally, `en_sh` is all-ones, and `fcnt` and `acc` are 0.
- Reset asserted mid-frame clears all state immediately (asynchronous). Outputs are 0 until 2 cycles after the first clock with `rst_n`=1.
- A `frame_start` with `de_in`=0 is legal. All frame actions still occur, and that cycle contributes no hit.
- `FLASH_DIV`=1: `flash_phase` toggles on every `frame_start`.

## Test plan
- **Priority.** N_LAYERS=4, `de_in`=1, layers 1 and 3 visible with colours 8'h1C and 8'h03, `bg_color`=8'hFF -> `pixel_out`=8'h1C two cycles later. Clear all visibility -> 8'hFF. Set `de_in`=0 -> 8'h00.
- **Colour key.** Layer 0 visible with colour 8'hE3, layer 2 visible with 8'h40 -> `pixel_out`=8'h40. With KEY_EN=0 -> 8'hE3.
- **Enable shadow.** Mid-frame, change `layer_enable_in` to 4'b1110 while layer 0 is visible -> no effect. On `frame_start` with 4'b1110 -> layer 0 is masked from that pixel onward.
- **Flash.** FLASH_DIV=2, `layer_flash`=4'b0001, pulse `frame_start` 4 times -> `flash_phase` goes 0→1 after the 2nd pulse and 1→0 after the 4th. Layer 0 is hidden only while the phase is 1.
- **Collision.** One pixel with layers 0 and 2 visible and `de_in`=1, then `frame_start` -> `collision_valid` pulses once, `collision_mask`=4'b0101. A following frame with no overlap -> mask 4'b0000.
- **Reset mid-operation.** Drop `rst_n` during active video -> all outputs read 0 immediately and `en_sh` returns to all-ones.

Source files
------------

// File: rtl/layer_priority_mixer.sv
// layer_priority_mixer: merges N_LAYERS keyed/flashing/enabled layers over a
// background colour with fixed index priority (layer 0 wins), in a two-stage
// pipeline, and reports a sticky per-frame collision mask.
module layer_priority_mixer #(
    parameter int                 N_LAYERS  = 4,
    parameter int                 COLOR_W   = 8,
    parameter bit                 KEY_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] KEY_COLOR = 'hE3,
    parameter int                 FLASH_DIV = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          de_in,
    input  logic                          frame_start,
    input  logic [COLOR_W-1:0]            bg_color,
    input  logic [N_LAYERS*COLOR_W-1:0]   layer_color,
    input  logic [N_LAYERS-1:0]           layer_visible,
    input  logic [N_LAYERS-1:0]           layer_enable_in,
    input  logic [N_LAYERS-1:0]           layer_flash,
    output logic                          de_out,
    output logic [COLOR_W-1:0]            pixel_out,
    output logic [N_LAYERS-1:0]           collision_mask,
    output logic                          collision_valid,
    output logic                          flash_phase
);

    // Frame-level state
    logic [N_LAYERS-1:0]         en_sh_q, en_sh_d;
    logic [7:0]                  fcnt_q, fcnt_d;
    logic                        flash_phase_q, flash_phase_d;
    logic [N_LAYERS-1:0]         acc_q, acc_d;
    logic [N_LAYERS-1:0]         coll_mask_q, coll_mask_d;
    logic                        coll_valid_q, coll_valid_d;

    // Pipeline stage 1
    logic [N_LAYERS*COLOR_W-1:0] s1_color_q, s1_color_d;
    logic [N_LAYERS-1:0]         s1_vis_q, s1_vis_d;
    logic                        s1_de_q, s1_de_d;
    logic [COLOR_W-1:0]          s1_bg_q, s1_bg_d;

    // Pipeline stage 2 (outputs)
    logic [COLOR_W-1:0]          pix_q, pix_d;
    logic                        de_out_q, de_out_d;

    // Stage 0 qualification
    logic [N_LAYERS-1:0]         en_eff;
    logic [N_LAYERS-1:0]         vis;
    logic [N_LAYERS-1:0]         hit;
    logic [3:0]                  vis_cnt;
    logic                        multi_vis;

    // The first pixel of a frame already sees the newly requested mask.
    assign en_eff = frame_start ? layer_enable_in : en_sh_q;

    generate
        for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_vis
            logic keyed;
            assign keyed   = KEY_EN && (layer_color[gi*COLOR_W +: COLOR_W] == KEY_COLOR);
            assign vis[gi] = layer_visible[gi] & en_eff[gi] & ~keyed
                           & ~(layer_flash[gi] & flash_phase_q);
        end
    endgenerate

    // Count visible layers to detect overlap on this pixel.
    always_comb begin
        vis_cnt = 4'd0;
        for (int i = 0; i < N_LAYERS; i++) begin
            vis_cnt = vis_cnt + {3'b000, vis[i]};
        end
        multi_vis = (vis_cnt >= 4'd2);
        hit       = (de_in && multi_vis) ? vis : '0;
    end

    // Frame bookkeeping: enable shadow, flash counter, collision accumulator.
    always_comb begin
        en_sh_d       = en_sh_q;
        fcnt_d        = fcnt_q;
        flash_phase_d = flash_phase_q;
        acc_d         = acc_q | hit;
        coll_mask_d   = coll_mask_q;
        coll_valid_d  = frame_start;
        if (frame_start) begin
            en_sh_d     = layer_enable_in;
            coll_mask_d = acc_q;
            acc_d       = hit;
            if (fcnt_q == 8'(FLASH_DIV - 1)) begin
                fcnt_d        = 8'd0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // Stage 0 -> 1 captures the qualified pixel.
    always_comb begin
        s1_color_d = layer_color;
        s1_vis_d   = vis;
        s1_de_d    = de_in;
        s1_bg_d    = bg_color;
    end

    // Stage 1 -> 2 resolves priority: scan from lowest priority so layer 0 wins.
    always_comb begin
        pix_d = s1_bg_q;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (s1_vis_q[i]) begin
                pix_d = s1_color_q[i*COLOR_W +: COLOR_W];
            end
        end
        if (!s1_de_q) begin
            pix_d = '0;
        end
        de_out_d = s1_de_q;
    end

    // State and pipeline registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sh_q       <= '1;
            fcnt_q        <= 8'd0;
            flash_phase_q <= 1'b0;
            acc_q         <= '0;
            coll_mask_q   <= '0;
            coll_valid_q  <= 1'b0;
            s1_color_q    <= '0;
            s1_vis_q      <= '0;
            s1_de_q       <= 1'b0;
            s1_bg_q       <= '0;
            pix_q         <= '0;
            de_out_q      <= 1'b0;
        end else begin
            en_sh_q       <= en_sh_d;
            fcnt_q        <= fcnt_d;
            flash_phase_q <= flash_phase_d;
            acc_q         <= acc_d;
            coll_mask_q   <= coll_mask_d;
            coll_valid_q  <= coll_valid_d;
            s1_color_q    <= s1_color_d;
            s1_vis_q      <= s1_vis_d;
            s1_de_q       <= s1_de_d;
            s1_bg_q       <= s1_bg_d;
            pix_q         <= pix_d;
            de_out_q      <= de_out_d;
        end
    end

    assign de_out          = de_out_q;
    assign pixel_out       = pix_q;
    assign collision_mask  = coll_mask_q;
    assign collision_valid = coll_valid_q;
    assign flash_phase     = flash_phase_q;

endmodule

// File: tb/tb_layer_priority_mixer.sv
// Testbench for layer_priority_mixer: two instances share stimulus
// (A: keyed, FLASH_DIV=2; B: unkeyed, FLASH_DIV=1) and are compared against a
// frame-level reference model every cycle, plus directed vectors.
module tb_layer_priority_mixer;

    localparam int N = 4;
    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            de_in, frame_start;
    logic [W-1:0]    bg;
    logic [N*W-1:0]  lc;
    logic [N-1:0]    lv, le, lf;

    logic            a_de, b_de, a_valid, b_valid, a_phase, b_phase;
    logic [W-1:0]    a_pix, b_pix;
    logic [N-1:0]    a_mask, b_mask;

    int checks = 0;
    int errors = 0;
    int nstep  = 0;

    // Reference model state
    logic [N-1:0] en_sh_m;
    int           k;
    logic [N-1:0] acc_a, acc_b, mask_a, mask_b;
    logic         vld_m;
    logic [W:0]   p1a, p2a, p1b, p2b;

    always #5 clk = ~clk;

    layer_priority_mixer #(.N_LAYERS(N), .COLOR_W(W), .KEY_EN(1'b1), .KEY_COLOR(8'hE3), .FLASH_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .frame_start(frame_start),
        .bg_color(bg), .layer_color(lc), .layer_visible(lv),
        .layer_enable_in(le), .layer_flash(lf),
        .de_out(a_de), .pixel_out(a_pix), .collision_mask(a_mask),
        .collision_valid(a_valid), .flash_phase(a_phase));

    layer_priority_mixer #(.N_LAYERS(N), .COLOR_W(W), .KEY_EN(1'b0), .KEY_COLOR(8'hE3), .FLASH_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .frame_start(frame_start),
        .bg_color(bg), .layer_color(lc), .layer_visible(lv),
        .layer_enable_in(le), .layer_flash(lf),
        .de_out(b_de), .pixel_out(b_pix), .collision_mask(b_mask),
        .collision_valid(b_valid), .flash_phase(b_phase));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, nstep);
        end
    endtask

    // Visibility from the rules: raw flag, enable, colour key, flash blanking.
    function automatic logic [N-1:0] visf(input logic [N-1:0] en, input logic phase, input logic key_en);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i] = lv[i] && en[i] && !(key_en && lc[i*W +: W] == 8'hE3) && !(lf[i] && phase);
        end
        return v;
    endfunction

    // First visible layer in index order, else background; blank when de is low.
    function automatic logic [W:0] mixf(input logic [N-1:0] v);
        if (!de_in) return '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) return {1'b1, lc[i*W +: W]};
        end
        return {1'b1, bg};
    endfunction

    task automatic model_reset();
        en_sh_m = '1; k = 0;
        acc_a = '0; acc_b = '0; mask_a = '0; mask_b = '0; vld_m = 1'b0;
        p1a = '0; p2a = '0; p1b = '0; p2b = '0;
    endtask

    // One pixel clock: predict, clock, then compare both instances.
    task automatic step();
        logic [N-1:0] en, va, vb, ha, hb;
        logic pa, pb;
        en = frame_start ? le : en_sh_m;
        pa = ((k / 2) % 2) == 1;
        pb = (k % 2) == 1;
        va = visf(en, pa, 1'b1);
        vb = visf(en, pb, 1'b0);
        ha = (de_in && $countones(va) >= 2) ? va : '0;
        hb = (de_in && $countones(vb) >= 2) ? vb : '0;
        if (frame_start) begin
            mask_a = acc_a; acc_a = ha;
            mask_b = acc_b; acc_b = hb;
            vld_m = 1'b1; k++; en_sh_m = le;
        end else begin
            acc_a = acc_a | ha; acc_b = acc_b | hb;
            vld_m = 1'b0;
        end
        p2a = p1a; p1a = mixf(va);
        p2b = p1b; p1b = mixf(vb);
        @(posedge clk);
        #1;
        nstep++;
        check("pipe_a", {17'd0, a_de, a_pix, a_valid, a_mask, a_phase},
              {17'd0, p2a, vld_m, mask_a, ((k / 2) % 2) == 1});
        check("pipe_b", {17'd0, b_de, b_pix, b_valid, b_mask, b_phase},
              {17'd0, p2b, vld_m, mask_b, (k % 2) == 1});
        $display("step %0d fs=%b de=%b lv=%b | A de=%b pix=%h v=%b m=%b ph=%b | B de=%b pix=%h v=%b m=%b ph=%b",
                 nstep, frame_start, de_in, lv, a_de, a_pix, a_valid, a_mask, a_phase,
                 b_de, b_pix, b_valid, b_mask, b_phase);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1; step(); frame_start = 1'b0;
    endtask

    // Assert reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_a_now", {a_de, a_pix, a_valid, a_mask, a_phase}, 0);
        check("rst_b_now", {b_de, b_pix, b_valid, b_mask, b_phase}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic           de;
        logic [W-1:0]   bg;
        logic [N*W-1:0] lc;
        logic [N-1:0]   lv;
        logic [W-1:0]   exp_a;
        logic [W-1:0]   exp_b;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 8'hFF, 32'h03_77_1C_77, 4'b1010, 8'h1C, 8'h1C};
        vecs[1] = '{1'b1, 8'hFF, 32'h03_77_1C_77, 4'b0000, 8'hFF, 8'hFF};
        vecs[2] = '{1'b0, 8'hFF, 32'h03_77_1C_77, 4'b1010, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 32'h00_40_00_E3, 4'b0101, 8'h40, 8'hE3};
        vecs[4] = '{1'b1, 8'h00, 32'h44_33_22_11, 4'b1111, 8'h11, 8'h11};
        vecs[5] = '{1'b1, 8'hAB, 32'hE3_00_00_00, 4'b1000, 8'hAB, 8'hE3};

        rst_n = 1'b0; de_in = 1'b0; frame_start = 1'b0;
        bg = '0; lc = '0; lv = '0; le = '1; lf = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", {a_de, a_pix, a_valid, a_mask, a_phase}, 0);
        check("reset_b", {b_de, b_pix, b_valid, b_mask, b_phase}, 0);
        rst_n = 1'b1;
        steps(2);

        // Priority and colour-key vectors
        for (int v = 0; v < 6; v++) begin
            de_in = vecs[v].de; bg = vecs[v].bg; lc = vecs[v].lc; lv = vecs[v].lv;
            steps(3);
            check("vec_a", {24'd0, a_pix}, {24'd0, vecs[v].exp_a});
            check("vec_b", {24'd0, b_pix}, {24'd0, vecs[v].exp_b});
        end

        // Enable shadow: mid-frame change ignored, frame_start applies it
        de_in = 1'b1; bg = 8'h00; lc = 32'h00_00_00_55; lv = 4'b0001; le = 4'b1110;
        steps(3);
        check("shadow_mid", {24'd0, a_pix}, 32'h55);
        pulse_fs();
        steps(2);
        check("shadow_fs", {24'd0, a_pix}, 32'h00);

        // Collision: one overlapping pixel, then a frame without overlap
        de_in = 1'b0; lv = 4'b0000; le = 4'b1111;
        pulse_fs();
        de_in = 1'b1; lc = 32'h00_33_00_11; lv = 4'b0101;
        step();
        lv = 4'b0000;
        steps(3);
        pulse_fs();
        check("coll_valid", {31'd0, a_valid}, 1);
        check("coll_mask", {28'd0, a_mask}, 32'h5);
        step();
        check("coll_valid_drop", {31'd0, a_valid}, 0);
        lv = 4'b0001;
        steps(3);
        pulse_fs();
        check("coll_mask_clear", {28'd0, a_mask}, 32'h0);

        // Flash from a clean reset: phase 0,1,1,0 after pulses 1..4
        do_reset();
        de_in = 1'b1; bg = 8'h0F; lc = 32'h00_00_00_55; lv = 4'b0001; lf = 4'b0001; le = 4'b1111;
        steps(2);
        for (int p = 1; p <= 4; p++) begin
            pulse_fs();
            check("flash_phase", {31'd0, a_phase}, (p == 2 || p == 3) ? 1 : 0);
            steps(2);
            check("flash_pix", {24'd0, a_pix}, (p == 2 || p == 3) ? 32'h0F : 32'h55);
        end
        lf = 4'b0000;

        // FLASH_DIV=1 boundary and frame_start with de low
        de_in = 1'b0;
        pulse_fs();
        check("div1_phase", {31'd0, b_phase}, 1);
        check("fs_no_de", {28'd0, a_mask}, 32'h0);

        // Reset mid-operation restores all-ones enable
        de_in = 1'b1; lv = 4'b0001; le = 4'b1110;
        pulse_fs();
        steps(3);
        check("pre_reset_masked", {24'd0, a_pix}, {24'd0, bg});
        do_reset();
        steps(3);
        check("post_reset_en", {24'd0, a_pix}, 32'h55);

        // Randomised traffic against the model
        for (int r = 0; r < 200; r++) begin
            de_in = ($urandom_range(0, 7) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            bg = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                lc[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
            end
            lv = 4'($urandom);
            le = 4'($urandom);
            lf = 4'($urandom);
            step();
        end
        frame_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
